fetch_decode_bundle_reg: RTL and testbench
==========================================

// Module: fetch_decode_bundle_reg
// PURPOSE
//   Parametrised N-lane fetch->decode pipeline register for the multi-issue front end.
//   - Carries one fetch bundle per cycle: instruction, PC, branch target and prediction per lane.
//   - Adds per-lane valid bits, a valid/ready handshake with a 2-entry skid buffer, and
//     whole-bundle flush. Per-lane kill has optional younger-lane propagation.
//   - Sits between the fetch unit and the first decode substage.
// PARAMETERS
//   LANES        2   issue width (lanes per bundle), >=1
//   XLEN         32  instruction width
//   PC_W         8   PC / branch-target width
//   KILL_YOUNGER 1   1: killing lane i also kills every lane j>i; 0: kill only the lanes in kill_mask
// PORTS
//   clk            in   1            clock, rising edge
//   reset          in   1            asynchronous, active-low
//   in_valid       in   1            fetch presents a bundle
//   in_ready       out  1            register can accept a bundle (registered)
//   in_inst        in   LANES*XLEN   lane i at [i*XLEN +: XLEN]
//   in_pc          in   LANES*PC_W   per-lane PC
//   in_target      in   LANES*PC_W   per-lane predicted branch target
//   in_pred        in   LANES        per-lane taken prediction
//   in_pc_next     in   PC_W         fall-through PC (pc of lane 0 + LANES)
//   kill_mask      in   LANES        per-lane squash of the incoming bundle
//   flush          in   1            squash everything held and the incoming bundle
//   out_valid      out  1            decode-side bundle present
//   out_ready      in   1            decode accepts (equals ~stall)
//   out_lane_valid out  LANES        per-lane valid of the presented bundle
//   out_inst, out_pc, out_target, out_pred, out_pc_next  out  (as inputs)  presented bundle
// BEHAVIOUR
//   - Reset: clears both entries asynchronously.
//     - All outputs 0; in_ready=1 from the first clock after reset deasserts.
//   - Storage: a main entry M, which drives the outputs, and a skid entry S.
//     - in_ready = ~S.full, registered.
//   - Accept: in_valid & in_ready & ~flush.
//     - Effective kill k: KILL_YOUNGER=1 gives k[i] = OR(kill_mask[0..i]); otherwise k = kill_mask.
//     - Lane valid = ~k[i]. Killed lanes store inst=NOP (0), pc=0, target=0, pred=0.
//     - An accepted bundle with every lane killed is consumed but not stored.
//   - Dequeue: out_valid & out_ready.
//   - Per-cycle update, priority order:
//     1. flush: M and S cleared; in_ready=1 next cycle; the same-cycle input is dropped.
//     2. Dequeue: M <= S if S full, else the accepted bundle, else empty.
//        S is filled only if it was full and a bundle is accepted (cannot happen, since in_ready=0).
//     3. No dequeue, M full, accept: the bundle goes to S; in_ready drops next cycle.
//     4. M empty, accept: the bundle goes to M.
//   - Latency: 1 cycle from accept to out_valid when M is empty. Throughput: 1 bundle/cycle
//     while out_ready=1.
//   - Order: bundles leave in arrival order; no bundle is duplicated or lost except by flush or full kill.
//   - out_valid=0: every out_* field reads 0; out_lane_valid=0.
//   - out_valid=1 with out_ready=0: every output holds stable.
//   - flush and kill_mask in the same cycle: flush dominates.
//   - reset asserted mid-transfer: both entries cleared immediately; no partial bundle survives.
// STRUCTURE
//   - Package fd_pkg: NOP_INST constant (32'h0) and a kill_prop function (prefix-OR over LANES).
//   - One sub-module, fd_bundle_slot: a single entry holding full flag, lane_valid and
//     fields, with load/clear. Instantiated twice, as M and S.
//   - The top level contains only the control logic and the kill/zeroing logic.
// TESTING
//   1. Reset with in_valid=1 -> out_valid=0, all outputs 0. First clk after release -> in_ready=1.
//   2. LANES=2: in pc={8'h05,8'h04}, inst={32'hA,32'hB}, out_ready=1
//      -> next cycle out_valid=1, out_lane_valid=2'b11, out_pc lane0=8'h04.
//   3. Stall: out_ready=0 for 3 cycles while feeding bundles B1,B2
//      -> B2 lands in S, in_ready=0 from cycle 2. Release -> B1 then B2 on consecutive cycles.
//   4. kill_mask=2'b01, KILL_YOUNGER=1 -> out_lane_valid=2'b00, bundle dropped, out_valid stays 0.
//      With KILL_YOUNGER=0 -> out_lane_valid=2'b10, lane0 inst=0.
//   5. M and S full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, input not stored.
//   6. Random valid/ready/kill stream against a scoreboard model
//      -> order preserved, killed lanes zeroed, no loss under stall.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared definitions for the fetch->decode bundle register.
//   NOP_INST  : instruction word written into killed lanes
//   MAX_LANES : widest bundle the helper functions support
//   kill_prop : prefix-OR of a kill mask, evaluated for one lane
package fd_pkg;

    localparam int          MAX_LANES = 16;
    localparam logic [31:0] NOP_INST  = 32'h0;

    // A lane is squashed when any lane at or below it (older or equal) is
    // squashed in the mask.
    function automatic logic kill_prop(input logic [MAX_LANES-1:0] mask,
                                       input int                   lane);
        logic r;
        r = 1'b0;
        for (int j = 0; j < MAX_LANES; j++) begin
            if (j <= lane) begin
                r = r | mask[j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fd_bundle_slot.sv
// One storage entry of the fetch->decode register: full flag, per-lane valid
// and the bundle fields.
//   clk, reset       : clock, asynchronous active-low reset
//   clear            : empty the entry and zero every field (wins over load)
//   load             : capture d_* and mark the entry full
//   d_* / q outputs  : bundle fields in, held bundle out (zero while empty)
module fd_bundle_slot
    import fd_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int PC_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [LANES-1:0]      d_lane_valid,
    input  logic [LANES*XLEN-1:0] d_inst,
    input  logic [LANES*PC_W-1:0] d_pc,
    input  logic [LANES*PC_W-1:0] d_target,
    input  logic [LANES-1:0]      d_pred,
    input  logic [PC_W-1:0]       d_pc_next,
    output logic                  full,
    output logic [LANES-1:0]      lane_valid,
    output logic [LANES*XLEN-1:0] inst,
    output logic [LANES*PC_W-1:0] pc,
    output logic [LANES*PC_W-1:0] target,
    output logic [LANES-1:0]      pred,
    output logic [PC_W-1:0]       pc_next
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full       <= 1'b0;
            lane_valid <= '0;
            inst       <= '0;
            pc         <= '0;
            target     <= '0;
            pred       <= '0;
            pc_next    <= '0;
        end else if (clear) begin
            full       <= 1'b0;
            lane_valid <= '0;
            for (int i = 0; i < LANES; i++) begin
                inst[i*XLEN +: XLEN] <= XLEN'(NOP_INST);
            end
            pc         <= '0;
            target     <= '0;
            pred       <= '0;
            pc_next    <= '0;
        end else if (load) begin
            full       <= 1'b1;
            lane_valid <= d_lane_valid;
            inst       <= d_inst;
            pc         <= d_pc;
            target     <= d_target;
            pred       <= d_pred;
            pc_next    <= d_pc_next;
        end
    end

endmodule

// File: rtl/fetch_decode_bundle_reg.sv
// N-lane fetch->decode pipeline register with valid/ready handshake, a
// two-entry (main + skid) buffer, whole-bundle flush and per-lane kill.
//   clk, reset      : clock, asynchronous active-low reset
//   in_valid/ready  : fetch-side handshake (in_ready is registered)
//   in_*            : incoming bundle, lane i at [i*W +: W]
//   kill_mask       : per-lane squash of the incoming bundle
//   flush           : drop everything held plus the incoming bundle
//   out_valid/ready : decode-side handshake
//   out_*           : presented bundle (all zero while out_valid=0)
module fetch_decode_bundle_reg
    import fd_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int XLEN         = 32,
    parameter int PC_W         = 8,
    parameter bit KILL_YOUNGER = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*XLEN-1:0] in_inst,
    input  logic [LANES*PC_W-1:0] in_pc,
    input  logic [LANES*PC_W-1:0] in_target,
    input  logic [LANES-1:0]      in_pred,
    input  logic [PC_W-1:0]       in_pc_next,
    input  logic [LANES-1:0]      kill_mask,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_valid,
    output logic [LANES*XLEN-1:0] out_inst,
    output logic [LANES*PC_W-1:0] out_pc,
    output logic [LANES*PC_W-1:0] out_target,
    output logic [LANES-1:0]      out_pred,
    output logic [PC_W-1:0]       out_pc_next
);

    logic [MAX_LANES-1:0]  mask_ext;
    logic [LANES-1:0]      kill_eff;
    logic [LANES-1:0]      nb_lane_valid;
    logic [LANES*XLEN-1:0] nb_inst;
    logic [LANES*PC_W-1:0] nb_pc;
    logic [LANES*PC_W-1:0] nb_target;
    logic [LANES-1:0]      nb_pred;

    logic                  m_full, s_full;
    logic                  m_load, m_clear, s_load, s_clear;
    logic                  accept, acc_store, deq;
    logic                  in_ready_q;

    logic [LANES-1:0]      s_lane_valid;
    logic [LANES*XLEN-1:0] s_inst;
    logic [LANES*PC_W-1:0] s_pc;
    logic [LANES*PC_W-1:0] s_target;
    logic [LANES-1:0]      s_pred;
    logic [PC_W-1:0]       s_pc_next;

    // Kill resolution and zeroing of squashed lanes.
    always_comb begin
        mask_ext              = '0;
        mask_ext[LANES-1:0]   = kill_mask;
        kill_eff              = '0;
        nb_inst               = '0;
        nb_pc                 = '0;
        nb_target             = '0;
        nb_pred               = '0;
        for (int i = 0; i < LANES; i++) begin
            kill_eff[i] = KILL_YOUNGER ? kill_prop(mask_ext, i) : kill_mask[i];
            if (kill_eff[i]) begin
                nb_inst[i*XLEN +: XLEN] = XLEN'(NOP_INST);
            end else begin
                nb_inst[i*XLEN +: XLEN]   = in_inst[i*XLEN +: XLEN];
                nb_pc[i*PC_W +: PC_W]     = in_pc[i*PC_W +: PC_W];
                nb_target[i*PC_W +: PC_W] = in_target[i*PC_W +: PC_W];
                nb_pred[i]                = in_pred[i];
            end
        end
        nb_lane_valid = ~kill_eff;
    end

    // A fully killed bundle is accepted (handshake completes) but never stored.
    always_comb begin
        accept    = in_valid & in_ready_q & ~flush;
        acc_store = accept & (|nb_lane_valid);
        deq       = m_full & out_ready;
        m_load    = ~flush & ((deq & (s_full | acc_store)) | (~m_full & acc_store));
        m_clear   = flush | (deq & ~s_full & ~acc_store);
        s_load    = ~flush & ~deq & m_full & ~s_full & acc_store;
        s_clear   = flush | (deq & s_full);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= ~(s_load | (s_full & ~s_clear));
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = m_full;

    // M reloads from S whenever S is occupied; otherwise from the new bundle.
    fd_bundle_slot #(.LANES(LANES), .XLEN(XLEN), .PC_W(PC_W)) u_slot_m (
        .clk          (clk),
        .reset        (reset),
        .clear        (m_clear),
        .load         (m_load),
        .d_lane_valid (s_full ? s_lane_valid : nb_lane_valid),
        .d_inst       (s_full ? s_inst       : nb_inst),
        .d_pc         (s_full ? s_pc         : nb_pc),
        .d_target     (s_full ? s_target     : nb_target),
        .d_pred       (s_full ? s_pred       : nb_pred),
        .d_pc_next    (s_full ? s_pc_next    : in_pc_next),
        .full         (m_full),
        .lane_valid   (out_lane_valid),
        .inst         (out_inst),
        .pc           (out_pc),
        .target       (out_target),
        .pred         (out_pred),
        .pc_next      (out_pc_next)
    );

    fd_bundle_slot #(.LANES(LANES), .XLEN(XLEN), .PC_W(PC_W)) u_slot_s (
        .clk          (clk),
        .reset        (reset),
        .clear        (s_clear),
        .load         (s_load),
        .d_lane_valid (nb_lane_valid),
        .d_inst       (nb_inst),
        .d_pc         (nb_pc),
        .d_target     (nb_target),
        .d_pred       (nb_pred),
        .d_pc_next    (in_pc_next),
        .full         (s_full),
        .lane_valid   (s_lane_valid),
        .inst         (s_inst),
        .pc           (s_pc),
        .target       (s_target),
        .pred         (s_pred),
        .pc_next      (s_pc_next)
    );

endmodule

// File: tb/tb_fetch_decode_bundle_reg.sv
module tb_fetch_decode_bundle_reg;

    typedef struct packed {
        logic [1:0]  lv;
        logic [63:0] inst;
        logic [15:0] pc;
        logic [15:0] tgt;
        logic [1:0]  pred;
        logic [7:0]  pcn;
    } bun_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_inst = '0;
    logic [15:0] in_pc = '0;
    logic [15:0] in_target = '0;
    logic [1:0]  in_pred = '0;
    logic [7:0]  in_pc_next = '0;
    logic [1:0]  kill_mask = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [1:0]  olv0, opred0, olv1, opred1;
    logic [63:0] oinst0, oinst1;
    logic [15:0] opc0, otgt0, opc1, otgt1;
    logic [7:0]  opcn0, opcn1;

    int   total = 0;
    int   bad   = 0;
    bit   live  = 1'b0;
    bun_t q0[$];
    bun_t q1[$];

    always #5 clk = ~clk;

    fetch_decode_bundle_reg #(.LANES(2), .XLEN(32), .PC_W(8), .KILL_YOUNGER(1'b1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_inst(in_inst), .in_pc(in_pc), .in_target(in_target), .in_pred(in_pred),
        .in_pc_next(in_pc_next), .kill_mask(kill_mask), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_lane_valid(olv0),
        .out_inst(oinst0), .out_pc(opc0), .out_target(otgt0), .out_pred(opred0),
        .out_pc_next(opcn0));

    fetch_decode_bundle_reg #(.LANES(2), .XLEN(32), .PC_W(8), .KILL_YOUNGER(1'b0)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_inst(in_inst), .in_pc(in_pc), .in_target(in_target), .in_pred(in_pred),
        .in_pc_next(in_pc_next), .kill_mask(kill_mask), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_lane_valid(olv1),
        .out_inst(oinst1), .out_pc(opc1), .out_target(otgt1), .out_pred(opred1),
        .out_pc_next(opcn1));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a lane dies if its own kill bit is set or, when younger-lane
    // propagation is on, if any older lane died.
    function automatic bun_t model(input bit ky, input logic [63:0] inst,
                                   input logic [15:0] pc, input logic [15:0] tgt,
                                   input logic [1:0] pred, input logic [7:0] pcn,
                                   input logic [1:0] kill);
        bun_t b;
        bit   dead;
        b    = '0;
        dead = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dead = ky ? (dead | kill[i]) : kill[i];
            if (!dead) begin
                b.lv[i]          = 1'b1;
                b.inst[i*32 +: 32] = inst[i*32 +: 32];
                b.pc[i*8 +: 8]   = pc[i*8 +: 8];
                b.tgt[i*8 +: 8]  = tgt[i*8 +: 8];
                b.pred[i]        = pred[i];
            end
        end
        b.pcn = pcn;
        return b;
    endfunction

    // Called at posedge+1; advances one clock.
    task automatic step(input logic iv, input logic [63:0] inst, input logic [15:0] pc,
                        input logic [15:0] tgt, input logic [1:0] pred, input logic [7:0] pcn,
                        input logic [1:0] kill, input logic fl, input logic ordy);
        bit   rdy0, rdy1;
        bun_t b;
        rdy0 = live && (q0.size() < 2);
        rdy1 = live && (q1.size() < 2);
        chk("in_ready0", in_ready0, rdy0);
        chk("in_ready1", in_ready1, rdy1);
        chk("out_valid0", out_valid0, q0.size() != 0);
        chk("out_valid1", out_valid1, q1.size() != 0);
        if (!out_valid0) chk("idle_zero0", {olv0, oinst0, opc0, otgt0, opred0, opcn0}, '0);
        if (!out_valid1) chk("idle_zero1", {olv1, oinst1, opc1, otgt1, opred1, opcn1}, '0);
        in_valid   = iv;
        in_inst    = inst;
        in_pc      = pc;
        in_target  = tgt;
        in_pred    = pred;
        in_pc_next = pcn;
        kill_mask  = kill;
        flush      = fl;
        out_ready  = ordy;
        if (fl) begin
            q0.delete();
            q1.delete();
        end else if (iv) begin
            if (rdy0) begin
                b = model(1'b1, inst, pc, tgt, pred, pcn, kill);
                if (b.lv != 2'b00) q0.push_back(b);
            end
            if (rdy1) begin
                b = model(1'b0, inst, pc, tgt, pred, pcn, kill);
                if (b.lv != 2'b00) q1.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        live = 1'b1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, ordy);
    endtask

    task automatic rnd_bundle(input logic ordy, input logic [1:0] kill);
        step(1'b1, {$urandom, $urandom}, 16'($urandom), 16'($urandom), 2'($urandom),
             8'($urandom), kill, 1'b0, ordy);
    endtask

    // Monitors: whatever is presented must be the oldest expected bundle;
    // it is retired only on a handshake.
    always @(negedge clk) begin
        if (reset && !flush && out_valid0) begin
            if (q0.size() == 0) begin
                chk("mon0_unexpected", out_valid0, 1'b0);
            end else begin
                chk("mon0_bundle", {olv0, oinst0, opc0, otgt0, opred0, opcn0}, q0[0]);
                if (out_ready) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset && !flush && out_valid1) begin
            if (q1.size() == 0) begin
                chk("mon1_unexpected", out_valid1, 1'b0);
            end else begin
                chk("mon1_bundle", {olv1, oinst1, opc1, otgt1, opred1, opcn1}, q1[0]);
                if (out_ready) void'(q1.pop_front());
            end
        end
    end

    initial begin
        // Reset held with a bundle offered.
        in_valid = 1'b1;
        in_inst  = 64'h1234_5678_9abc_def0;
        in_pc    = 16'h0102;
        #12;
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_in_ready", in_ready0, 1'b0);
        chk("rst_outputs", {olv0, oinst0, opc0, otgt0, opred0, opcn0}, '0);
        in_valid = 1'b0;
        #10 reset = 1'b1;
        @(posedge clk);
        #1;
        live = 1'b1;
        chk("rst_release_ready", in_ready0, 1'b1);

        // Single bundle, lane0 pc 04.
        step(1'b1, {32'hA, 32'hB}, {8'h05, 8'h04}, {8'h20, 8'h10}, 2'b10, 8'h06, 2'b00, 1'b0, 1'b1);
        chk("t2_lane_valid", olv0, 2'b11);
        chk("t2_pc_lane0", opc0[7:0], 8'h04);
        idle(1'b1);

        // Stall: B1 to M, B2 to S, then drain in order.
        rnd_bundle(1'b0, 2'b00);
        rnd_bundle(1'b0, 2'b00);
        chk("t3_skid_full_ready", in_ready0, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Kill lane 0.
        step(1'b1, {32'hC, 32'hD}, {8'h09, 8'h08}, '0, 2'b11, 8'h0a, 2'b01, 1'b0, 1'b1);
        chk("t4_ky1_dropped", out_valid0, 1'b0);
        chk("t4_ky0_lane_valid", olv1, 2'b10);
        chk("t4_ky0_lane0_nop", oinst1[31:0], 32'h0);
        idle(1'b1);

        // Flush with both entries full and a bundle offered.
        rnd_bundle(1'b0, 2'b00);
        rnd_bundle(1'b0, 2'b00);
        step(1'b1, {32'hE, 32'hF}, 16'h3333, 16'h4444, 2'b01, 8'h55, 2'b10, 1'b1, 1'b0);
        chk("t5_flush_out_valid", out_valid0, 1'b0);
        chk("t5_flush_in_ready", in_ready0, 1'b1);
        idle(1'b1);

        // Random stream.
        for (int n = 0; n < 1500; n++) begin
            logic [1:0] k;
            k = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
            step(($urandom_range(3) != 0), {$urandom, $urandom}, 16'($urandom), 16'($urandom),
                 2'($urandom), 8'($urandom), k, ($urandom_range(39) == 0),
                 ($urandom_range(2) != 0));
        end
        for (int n = 0; n < 4; n++) idle(1'b1);

        // Reset asserted with both entries occupied.
        rnd_bundle(1'b0, 2'b00);
        rnd_bundle(1'b0, 2'b00);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midrst_out_valid0", out_valid0, 1'b0);
        chk("midrst_out_valid1", out_valid1, 1'b0);
        chk("midrst_in_ready", in_ready0, 1'b0);
        q0.delete();
        q1.delete();
        live = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        live = 1'b1;
        rnd_bundle(1'b1, 2'b00);
        idle(1'b1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
